// File: rtl/rtmq_trig_gen_pkg.sv
// rtmq_trig_gen_pkg: shared peripheral constants for the trigger generator
//   W_REG / W_ADR / W_ALU : register width, register address width, ALU bus width
//   alu_wr_t              : layout of a register write carried on alu_out
//   R_TG*                 : trigger generator register addresses
//   S_*                   : FSM state encoding (S_GAP only reachable with RTMQ_TRIG_GEN_REPEAT_EN)
//   max1()                : clamps a zero count to one
package rtmq_trig_gen_pkg;
   localparam int W_REG = 32;
   localparam int W_ADR = 8;
   typedef struct packed {
      logic             wen;
      logic [W_ADR-1:0] adr;
      logic [W_REG-1:0] dat;
   } alu_wr_t;
   localparam int W_ALU = $bits(alu_wr_t);
   localparam logic [W_ADR-1:0] R_TGMSK = 8'h20;
   localparam logic [W_ADR-1:0] R_TGWID = 8'h21;
   localparam logic [W_ADR-1:0] R_TGDLY = 8'h22;
   localparam logic [W_ADR-1:0] R_TGRPT = 8'h23;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DELAY = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;
   function automatic logic [W_REG-1:0] max1(input logic [W_REG-1:0] v);
      return (v == '0) ? W_REG'(1) : v;
   endfunction
endpackage

// File: rtl/rtmq_trig_timer.sv
// rtmq_trig_timer: loadable down-counter with a terminal pulse
//   clk, rst : clock, asynchronous active-high reset
//   ld       : load ld_val (has priority over counting)
//   ld_val   : count to load
//   en       : count enable; the owning FSM state is active
//   tc       : terminal pulse, high while enabled with the count at 1
module rtmq_trig_timer
   import rtmq_trig_gen_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [W_REG-1:0] ld_val,
   input  logic             en,
   output logic             tc
);
   logic [W_REG-1:0] cnt;
   // Counting stops at 1 so the counter never wraps.
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (en && cnt > W_REG'(1)) cnt <= cnt - W_REG'(1);
   assign tc = en && (cnt <= W_REG'(1));
endmodule

// File: rtl/rtmq_trig_gen.sv
// rtmq_trig_gen: delayed, width-programmable trigger pulse generator
//   clk, rst : clock, asynchronous active-high reset
//   alu_out  : ALU bus carrying register writes (alu_wr_t); a R_TGMSK write fires
//   f_hld    : hold-state indicator, clears f_done
//   trg_out  : registered trigger pulses, one bit per channel
//   f_busy   : sequence in progress
//   f_done   : sequence complete (set wins over f_hld)
//   f_ovr    : sticky, a fire write was dropped while busy
// Optional: RTMQ_TRIG_GEN_REPEAT_EN adds R_TGRPT and the GAP state for pulse trains.
module rtmq_trig_gen
   import rtmq_trig_gen_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [W_ALU-1:0] alu_out,
   input  logic             f_hld,
   output logic [W_REG-1:0] trg_out,
   output logic             f_busy,
   output logic             f_done,
   output logic             f_ovr
);
   alu_wr_t          wr;
   logic [1:0]       state, state_n;
   logic [W_REG-1:0] reg_wid, reg_dly, lat_msk, lat_wid, wid_val;
   logic             fire, accept, drop, dly_tc, wid_tc, wid_ld, gap_tc, more, fin;
   assign wr     = alu_out;
   assign fire   = wr.wen && wr.adr == R_TGMSK;
   assign accept = fire && state == S_IDLE;
   assign drop   = fire && state != S_IDLE;
   // The mask write is the fire strobe: its data is latched directly, so no
   // separate stored mask is kept.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         reg_wid <= '0;
         reg_dly <= '0;
      end else if (wr.wen) begin
         if (wr.adr == R_TGWID) reg_wid <= wr.dat;
         if (wr.adr == R_TGDLY) reg_dly <= wr.dat;
      end
`ifdef RTMQ_TRIG_GEN_REPEAT_EN
   logic [W_REG-1:0]   reg_rpt;
   logic [W_REG/2-1:0] lat_per, rpt_left;
   logic               gap_ld;
   assign more   = rpt_left != '0;
   assign gap_ld = state == S_PULSE && wid_tc && more;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         reg_rpt  <= '0;
         lat_per  <= '0;
         rpt_left <= '0;
      end else begin
         if (wr.wen && wr.adr == R_TGRPT) reg_rpt <= wr.dat;
         if (accept) begin
            lat_per  <= reg_rpt[W_REG-1:W_REG/2];
            rpt_left <= reg_rpt[W_REG/2-1:0];
         end else if (gap_ld) rpt_left <= rpt_left - 1'b1;
      end
   rtmq_trig_timer u_gap (
      .clk    (clk),
      .rst    (rst),
      .ld     (gap_ld),
      .ld_val (max1({{(W_REG/2){1'b0}}, lat_per})),
      .en     (state == S_GAP),
      .tc     (gap_tc)
   );
`else
   assign more   = 1'b0;
   assign gap_tc = 1'b0;
`endif
   assign fin     = state == S_PULSE && wid_tc && !more;
   // Width counter is (re)loaded whenever PULSE is about to be entered; on the
   // fire cycle the latch is not yet valid, so the stored register is used.
   assign wid_ld  = (accept && reg_dly == '0) || (state == S_DELAY && dly_tc) || (state == S_GAP && gap_tc);
   assign wid_val = max1(accept ? reg_wid : lat_wid);
   assign state_n = (state == S_IDLE)  ? (accept ? ((reg_dly != '0) ? S_DELAY : S_PULSE) : S_IDLE) :
                    (state == S_DELAY) ? (dly_tc ? S_PULSE : S_DELAY) :
                    (state == S_PULSE) ? (wid_tc ? (more ? S_GAP : S_IDLE) : S_PULSE) :
                                         (gap_tc ? S_PULSE : S_GAP);
   rtmq_trig_timer u_dly (
      .clk    (clk),
      .rst    (rst),
      .ld     (accept),
      .ld_val (reg_dly),
      .en     (state == S_DELAY),
      .tc     (dly_tc)
   );
   rtmq_trig_timer u_wid (
      .clk    (clk),
      .rst    (rst),
      .ld     (wid_ld),
      .ld_val (wid_val),
      .en     (state == S_PULSE),
      .tc     (wid_tc)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= S_IDLE;
         trg_out <= '0;
         f_busy  <= 1'b0;
         f_done  <= 1'b0;
         f_ovr   <= 1'b0;
         lat_msk <= '0;
         lat_wid <= '0;
      end else begin
         state   <= state_n;
         trg_out <= (state_n == S_PULSE) ? (accept ? wr.dat : lat_msk) : '0;
         f_busy  <= state_n != S_IDLE;
         f_done  <= fin | (f_done & ~f_hld);
         f_ovr   <= accept ? 1'b0 : (drop | f_ovr);
         if (accept) begin
            lat_msk <= wr.dat;
            lat_wid <= reg_wid;
         end
      end
endmodule

// File: tb/tb_rtmq_trig_gen.sv
// tb_rtmq_trig_gen: scoreboard bench for rtmq_trig_gen (directed vectors)
module tb_rtmq_trig_gen;
   import rtmq_trig_gen_pkg::*;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [W_ALU-1:0] alu_out = '0;
   logic             f_hld = 1'b0;
   logic [W_REG-1:0] trg_out;
   logic             f_busy, f_done, f_ovr;
   typedef struct {
      int               id;
      logic [W_REG-1:0] trg;
      logic             busy;
      logic             done;
      logic             ovr;
   } exp_t;
   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   step_id = 0;
   localparam logic [W_ALU-1:0] NOP = '0;
   rtmq_trig_gen dut (
      .clk     (clk),
      .rst     (rst),
      .alu_out (alu_out),
      .f_hld   (f_hld),
      .trg_out (trg_out),
      .f_busy  (f_busy),
      .f_done  (f_done),
      .f_ovr   (f_ovr)
   );
   always #5 clk = ~clk;
   function automatic logic [W_ALU-1:0] wr(input logic [W_ADR-1:0] a, input logic [W_REG-1:0] d);
      return {1'b1, a, d};
   endfunction
   task automatic check(input string nm, input logic [W_REG+2:0] got, input logic [W_REG+2:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got {trg,busy,done,ovr}=%h required %h", nm, got, exp);
   endtask
   // Drive one cycle of stimulus and queue what the outputs must be after the edge.
   task automatic step(input logic [W_ALU-1:0] a, input logic h, input logic [W_REG-1:0] t,
                       input logic b, input logic d, input logic o);
      @(negedge clk);
      alu_out = a;
      f_hld   = h;
      q.push_back('{step_id, t, b, d, o});
      step_id++;
   endtask
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         check($sformatf("step%0d", e.id), {trg_out, f_busy, f_done, f_ovr}, {e.trg, e.busy, e.done, e.ovr});
      end
   end
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(NOP, 0, 0, 0, 0, 0);
      step(NOP, 0, 0, 0, 0, 0);
      // width 3, no delay, mask 5
      step(wr(R_TGWID, 3), 0, 0, 0, 0, 0);
      step(wr(R_TGDLY, 0), 0, 0, 0, 0, 0);
      step(wr(R_TGMSK, 5), 0, 5, 1, 0, 0);
      step(NOP, 0, 5, 1, 0, 0);
      step(NOP, 0, 5, 1, 0, 0);
      step(NOP, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 1, 0);
      step(NOP, 1, 0, 0, 0, 0);
      // width 2, delay 4; f_hld coincident with done set, then alone
      step(wr(R_TGWID, 2), 0, 0, 0, 0, 0);
      step(wr(R_TGDLY, 4), 0, 0, 0, 0, 0);
      step(wr(R_TGMSK, 1), 0, 0, 1, 0, 0);
      step(NOP, 0, 0, 1, 0, 0);
      step(NOP, 0, 0, 1, 0, 0);
      step(NOP, 0, 0, 1, 0, 0);
      step(NOP, 0, 1, 1, 0, 0);
      step(NOP, 0, 1, 1, 0, 0);
      step(NOP, 1, 0, 0, 1, 0);
      step(NOP, 1, 0, 0, 0, 0);
      // width 0 -> 1; dropped fire sets f_ovr; fire on first idle cycle clears it
      step(wr(R_TGDLY, 0), 0, 0, 0, 0, 0);
      step(wr(R_TGWID, 0), 0, 0, 0, 0, 0);
      step(wr(R_TGMSK, 8), 0, 8, 1, 0, 0);
      step(wr(R_TGMSK, 4), 0, 0, 0, 1, 1);
      step(wr(R_TGMSK, 2), 0, 2, 1, 1, 0);
      step(NOP, 0, 0, 0, 1, 0);
      // width write while busy affects only the next sequence
      step(wr(R_TGWID, 3), 1, 0, 0, 0, 0);
      step(wr(R_TGMSK, 1), 0, 1, 1, 0, 0);
      step(wr(R_TGWID, 1), 0, 1, 1, 0, 0);
      step(NOP, 0, 1, 1, 0, 0);
      step(NOP, 0, 0, 0, 1, 0);
      step(wr(R_TGMSK, 3), 1, 3, 1, 0, 0);
      step(NOP, 0, 0, 0, 1, 0);
      // mask 0: sequence runs, no pulse, done still set
      step(wr(R_TGMSK, 0), 1, 0, 1, 0, 0);
      step(NOP, 0, 0, 0, 1, 0);
`ifdef RTMQ_TRIG_GEN_REPEAT_EN
      // period 3, count 2, width 1: pulses 4 cycles apart
      step(wr(R_TGRPT, 32'h0003_0002), 1, 0, 0, 0, 0);
      step(wr(R_TGMSK, 1), 0, 1, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         repeat (3) step(NOP, 0, 0, 1, 0, 0);
         step(NOP, 0, 1, 1, 0, 0);
      end
      step(NOP, 0, 0, 0, 1, 0);
`else
      // repeat register does not exist: a single pulse
      step(wr(R_TGRPT, 32'h0003_0002), 1, 0, 0, 0, 0);
      step(wr(R_TGMSK, 1), 0, 1, 1, 0, 0);
      step(NOP, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 1, 0);
`endif
      // asynchronous reset mid-pulse
      step(wr(R_TGWID, 10), 1, 0, 0, 0, 0);
      step(wr(R_TGMSK, 6), 0, 6, 1, 0, 0);
      step(NOP, 0, 6, 1, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async_rst", {trg_out, f_busy, f_done, f_ovr}, '0);
      @(negedge clk);
      rst = 1'b0;
      step(NOP, 0, 0, 0, 0, 0);
      step(wr(R_TGMSK, 1), 0, 1, 1, 0, 0);
      step(NOP, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 1, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain got %0d pending entries required 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rtmq_trig_gen.md
RTMQ_TRIG_GEN -- requirements
Module: rtmq_trig_gen

Interface
REQ-001 SHALL take parameters from the shared peripheral constants: W_ALU (ALU bus width) and W_REG (register/channel width).
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 alu_out  input  W_ALU  ALU output bus, carrying register writes.
REQ-005 f_hld  input  1  hold-state indicator; clears f_done.
REQ-006 trg_out  output  W_REG  trigger pulse outputs, registered, one bit per channel.
REQ-007 f_busy  output  1  high while a sequence is in progress.
REQ-008 f_done  output  1  sequence-complete flag; used to resume the hold state.
REQ-009 f_ovr  output  1  sticky flag: a fire write was dropped because the block was busy.

Function
REQ-010 SHALL decode these registers from alu_out: R_TGMSK (channel mask; a write is the fire strobe), R_TGWID (pulse width in cycles), R_TGDLY (delay in cycles).
REQ-011 SHALL run an FSM with states IDLE, DELAY and PULSE, plus GAP when REPEAT is compiled in.
REQ-012 IDLE + fire strobe: latch the mask, width and delay; go to DELAY if delay>0, else to PULSE.
REQ-013 DELAY: count delay cycles, then go to PULSE.
REQ-014 Latency: with delay=0, trg_out = mask on the cycle after the strobe; with delay=D, trg_out = mask D cycles after that.
REQ-015 PULSE: hold trg_out = latched mask for max(width,1) cycles, then drive trg_out to 0 and return to IDLE.
REQ-016 width=0 SHALL be treated as 1, so a pulse is never lost.
REQ-017 mask=0: the timing sequence runs unchanged, trg_out stays 0, and f_done is still set.
REQ-018 f_busy = (state != IDLE), registered.
REQ-019 Register writes while busy SHALL update the stored values but not the latched values of the running sequence.
REQ-020 A fire strobe while busy SHALL be dropped and SHALL set f_ovr; f_ovr clears only on the next accepted fire strobe.
REQ-021 f_done SHALL set on the cycle trg_out returns to 0 at the end of the sequence.
REQ-022 f_done SHALL be a set-priority flag: simultaneous set and f_hld leaves it set; f_hld alone clears it.
REQ-023 A fire strobe accepted in the same cycle the FSM enters IDLE SHALL start a new sequence.
REQ-024 All counters are W_REG bits wide and count down to 1; there is no wrap-around.

Reset
REQ-025 On rst: state=IDLE, trg_out=0, f_busy=0, f_done=0, f_ovr=0, all counters=0, registers R_TGMSK/R_TGWID/R_TGDLY=0.
REQ-026 rst asserted mid-sequence SHALL force trg_out to 0 immediately (asynchronous) and SHALL NOT set f_done.

Configuration
REQ-027 Macro RTMQ_TRIG_GEN_REPEAT_EN.
REQ-028 Defined: adds register R_TGRPT = {period[W_REG/2-1:0] in the upper half, count[W_REG/2-1:0] in the lower half}.
REQ-029 Defined: after PULSE, if remaining count>0, go to GAP for max(period,1) cycles with trg_out=0, then return to PULSE.
REQ-030 Defined: count=0 means a single pulse, and f_done sets only after the final pulse.
REQ-031 Undefined: no R_TGRPT, no GAP state; behaviour is exactly REQ-012..REQ-024.

Structure
REQ-032 Register addresses R_TGMSK, R_TGWID, R_TGDLY and R_TGRPT, and the FSM state encoding, SHALL live in the shared peripheral constants package.
REQ-033 Register decode SHALL reuse the existing general-purpose register block; its write strobe provides the fire signal.
REQ-034 One sub-module, rtmq_trig_timer (loadable down-counter with a terminal pulse), instanced for the delay, width and gap counts.

Verification
REQ-035 Write WID=3, DLY=0, MSK=0x5 -> trg_out=0x5 for exactly 3 cycles starting 1 cycle after the strobe; f_done rises as trg_out falls.
REQ-036 Write WID=2, DLY=4, MSK=0x1 -> f_busy for 6 cycles; pulse starts 5 cycles after the strobe.
REQ-037 WID=0, MSK=0x8 -> 1-cycle pulse; second MSK write while busy -> dropped, f_ovr=1; next accepted fire -> f_ovr=0.
REQ-038 f_hld asserted in the same cycle f_done sets -> f_done=1; f_hld on the next cycle -> f_done=0.
REQ-039 rst mid-PULSE with WID=10 -> trg_out=0 asynchronously, FSM in IDLE, f_done stays 0.
REQ-040 With REPEAT_EN: RPT count=2, period=3, WID=1 -> three 1-cycle pulses spaced 4 cycles apart; f_done after the third pulse.
